rtc_bus_responder: RTL

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

---
 rtl/rtc_bus_if.sv | 35 +++
 rtl/rtc_bus_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_if.sv
// rtc_bus_if
//   Control side of the multiplexed RTC host bus. The 8-bit address/data
//   lines stay a plain inout port on the responder so tristate resolution
//   remains at module level.
//   Signals:
//     CS_n     chip select, active-low
//     AD_n     0 = address phase, 1 = data phase
//     WR_n     write strobe, active-low
//     RD_n     read strobe, active-low
//     ADDR_REG last committed address (debug visibility)
//   Modports: master (host side), slave (responder side).

interface rtc_bus_if;
    logic       CS_n;
    logic       AD_n;
    logic       WR_n;
    logic       RD_n;
    logic [7:0] ADDR_REG;

    modport master (
        output CS_n,
        output AD_n,
        output WR_n,
        output RD_n,
        input  ADDR_REG
    );

    modport slave (
        input  CS_n,
        input  AD_n,
        input  WR_n,
        input  RD_n,
        output ADDR_REG
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
//   Real-time-clock register block behind a multiplexed 8-bit bus.
//   Registers (all BCD): 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes,
//   0x26 ano, 0x41 segcr, 0x42 mincr, 0x43 horacr. Unmapped addresses read
//   0x00 and ignore writes.
//   Ports:
//     reloj     system clock, rising edge
//     resetM    asynchronous active-high reset
//     bus       rtc_bus_if.slave (CS_n, AD_n, WR_n, RD_n in; ADDR_REG out)
//     DIR_DATO  8-bit address/data bus, high-Z unless returning read data
//   Parameter:
//     TICK_DIV  reloj cycles per one-second tick (>= 2)
//   Build option:
//     RTC_TICK_EN  when defined, a free-running divider advances
//                  seg/min/hora once per TICK_DIV cycles. When undefined the
//                  registers change only through bus writes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | not selected, waiting for an address phase
//   ADDR  | address phase, bus sampled until WR_n rises
//   WAIT  | address committed, waiting for a read or write data phase
//   READ  | read data phase, bus driven one cycle after RD_n low seen
//   WRITE | write data phase, data committed when WR_n rises

module rtc_bus_responder #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       reloj,
    input  logic       resetM,
    rtc_bus_if.slave   bus,
    inout  wire  [7:0] DIR_DATO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [7:0] A_SEG    = 8'h21;
    localparam logic [7:0] A_MIN    = 8'h22;
    localparam logic [7:0] A_HORA   = 8'h23;
    localparam logic [7:0] A_DIA    = 8'h24;
    localparam logic [7:0] A_MES    = 8'h25;
    localparam logic [7:0] A_ANO    = 8'h26;
    localparam logic [7:0] A_SEGCR  = 8'h41;
    localparam logic [7:0] A_MINCR  = 8'h42;
    localparam logic [7:0] A_HORACR = 8'h43;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] smp_q, smp_d;
    logic [7:0] rdat_q, rdat_d;
    logic       oe_q, oe_d;
    logic       wr_en;
    logic [7:0] rd_mux;

    logic [7:0] seg_q, seg_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hora_q, hora_d;
    logic [7:0] dia_q, dia_d;
    logic [7:0] mes_q, mes_d;
    logic [7:0] ano_q, ano_d;
    logic [7:0] segcr_q, segcr_d;
    logic [7:0] mincr_q, mincr_d;
    logic [7:0] horacr_q, horacr_d;

    // oe_q is cleared by the async reset, so the bus is released without
    // waiting for a clock edge.
    assign DIR_DATO     = oe_q ? rdat_q : 8'hzz;
    assign bus.ADDR_REG = addr_q;

    always_comb begin
        rd_mux = 8'h00;
        case (addr_q)
            A_SEG:    rd_mux = seg_q;
            A_MIN:    rd_mux = min_q;
            A_HORA:   rd_mux = hora_q;
            A_DIA:    rd_mux = dia_q;
            A_MES:    rd_mux = mes_q;
            A_ANO:    rd_mux = ano_q;
            A_SEGCR:  rd_mux = segcr_q;
            A_MINCR:  rd_mux = mincr_q;
            A_HORACR: rd_mux = horacr_q;
            default:  rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oe_d    = oe_q;
        rdat_d  = rdat_q;
        wr_en   = 1'b0;
        // One shared sample register serves both address and write data:
        // whatever was on the bus in the last cycle with WR_n low is what
        // gets committed when WR_n rises.
        smp_d   = (!bus.CS_n && !bus.WR_n) ? DIR_DATO : smp_q;

        if (bus.CS_n) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.AD_n && !bus.WR_n) state_d = S_ADDR;
                end
                S_ADDR: begin
                    if (bus.WR_n) begin
                        addr_d  = smp_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // RD_n and WR_n both low is a protocol error: hold here.
                    if (bus.AD_n) begin
                        if (!bus.RD_n && bus.WR_n)      state_d = S_READ;
                        else if (!bus.WR_n && bus.RD_n) state_d = S_WRITE;
                    end else if (!bus.WR_n && bus.RD_n) begin
                        state_d = S_ADDR;
                    end
                end
                S_READ: begin
                    if (bus.RD_n) begin
                        state_d = S_WAIT;
                        oe_d    = 1'b0;
                    end else if (!oe_q) begin
                        // Captured once per read so ticks cannot disturb the
                        // value while it is on the bus.
                        oe_d   = 1'b1;
                        rdat_d = rd_mux;
                    end
                end
                S_WRITE: begin
                    if (bus.WR_n) begin
                        wr_en   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef RTC_TICK_EN
    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic             wr_seg, wr_min;
    logic             carry_seg, carry_min;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);

    // A bus write to a register in the tick cycle wins and kills the carry
    // that register would otherwise have passed on.
    assign wr_seg    = wr_en && (addr_q == A_SEG);
    assign wr_min    = wr_en && (addr_q == A_MIN);
    assign carry_seg = tick && !wr_seg && (seg_q == 8'h59);
    assign carry_min = carry_seg && !wr_min && (min_q == 8'h59);

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick_cnt_d;
    end
`else
    logic [31:0] unused_tick_div;
    assign unused_tick_div = TICK_DIV;
`endif

    always_comb begin
        seg_d    = seg_q;
        min_d    = min_q;
        hora_d   = hora_q;
        dia_d    = dia_q;
        mes_d    = mes_q;
        ano_d    = ano_q;
        segcr_d  = segcr_q;
        mincr_d  = mincr_q;
        horacr_d = horacr_q;
`ifdef RTC_TICK_EN
        if (tick)      seg_d  = (seg_q  == 8'h59) ? 8'h00 : bcd_inc(seg_q);
        if (carry_seg) min_d  = (min_q  == 8'h59) ? 8'h00 : bcd_inc(min_q);
        if (carry_min) hora_d = (hora_q == 8'h23) ? 8'h00 : bcd_inc(hora_q);
`endif
        if (wr_en) begin
            case (addr_q)
                A_SEG:    seg_d    = smp_q;
                A_MIN:    min_d    = smp_q;
                A_HORA:   hora_d   = smp_q;
                A_DIA:    dia_d    = smp_q;
                A_MES:    mes_d    = smp_q;
                A_ANO:    ano_d    = smp_q;
                A_SEGCR:  segcr_d  = smp_q;
                A_MINCR:  mincr_d  = smp_q;
                A_HORACR: horacr_d = smp_q;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state_q  <= S_IDLE;
            addr_q   <= 8'h00;
            smp_q    <= 8'h00;
            rdat_q   <= 8'h00;
            oe_q     <= 1'b0;
            seg_q    <= 8'h00;
            min_q    <= 8'h00;
            hora_q   <= 8'h00;
            dia_q    <= 8'h00;
            mes_q    <= 8'h00;
            ano_q    <= 8'h00;
            segcr_q  <= 8'h00;
            mincr_q  <= 8'h00;
            horacr_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            smp_q    <= smp_d;
            rdat_q   <= rdat_d;
            oe_q     <= oe_d;
            seg_q    <= seg_d;
            min_q    <= min_d;
            hora_q   <= hora_d;
            dia_q    <= dia_d;
            mes_q    <= mes_d;
            ano_q    <= ano_d;
            segcr_q  <= segcr_d;
            mincr_q  <= mincr_d;
            horacr_q <= horacr_d;
        end
    end

endmodule
